multicycle_control_fsm: RTL and testbench
=========================================

# multicycle_control_fsm

Multi-cycle sequencing controller for the MIPS-subset datapath (R-type, LW, SW, BEQ, ADDI, J). It replaces single-cycle decode with a Moore state machine that steps the shared ALU/memory datapath through fetch, decode, execute, memory and writeback. Memory accesses use a ready handshake, so the controller stalls on slow memory. It sits between the instruction register's opcode field and the datapath muxes and enables.

## Interface
- No parameters; state encoding is a fixed 4-bit field.
- clk  in  1  system clock, all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- Opcode  in  6  IR[31:26]; datapath holds it stable outside FETCH
- mem_ready  in  1  memory completes the current read/write this cycle
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite  out  1 each  datapath enables/selects
- MemtoReg, RegDst, RegWrite, AluSrcA  out  1 each  register-file/ALU selects
- AluSrcB  out  2  00 regB, 01 const 4, 10 sign-ext imm, 11 imm<<2
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target
- AluOp  out  2  00 add, 01 sub, 10 funct-decoded
- instr_done  out  1  one-cycle pulse on an instruction's final cycle
- illegal_op  out  1  one-cycle pulse on an unsupported opcode
- state  out  4  current state, for debug/verification

## Operation
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11. Codes 12-15 are unused and go to FETCH next cycle.
- Outputs are combinational from state (plus mem_ready where noted). Every output not listed for a state is 0.
- FETCH: MemRead=1, IorD=0, AluSrcA=0, AluSrcB=01, AluOp=00, PCSource=00. IRWrite=PCWrite=mem_ready. Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: AluSrcA=0, AluSrcB=11, AluOp=00. Next state by Opcode:
  - 100011 or 101011 -> MEMADR
  - 000000 -> EXECUTE
  - 000100 -> BRANCH
  - 001000 -> ADDIEX
  - 000010 -> JUMP
  - any other -> FETCH, with illegal_op=1
- MEMADR: AluSrcA=1, AluSrcB=10, AluOp=00. Goes to MEMRD if Opcode=100011, else MEMWR.
- MEMRD: IorD=1, MemRead=1. Holds until mem_ready=1, then MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1. Then FETCH.
- MEMWR: IorD=1, MemWrite=1, held until mem_ready=1. In the cycle mem_ready=1: instr_done=1, next state FETCH.
- EXECUTE: AluSrcA=1, AluSrcB=00, AluOp=10. Then ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1, instr_done=1. Then FETCH.
- BRANCH: AluSrcA=1, AluSrcB=00, AluOp=01, PCSource=01, PCWriteCond=1, instr_done=1. Then FETCH.
- ADDIEX: AluSrcA=1, AluSrcB=10, AluOp=00. Then ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1, instr_done=1. Then FETCH.
- JUMP: PCSource=10, PCWrite=1, instr_done=1. Then FETCH.
- Simultaneous events: mem_ready is ignored in every state except FETCH, MEMRD and MEMWR.
- Opcode is ignored in every state except DECODE and MEMADR.

## Timing
- Reset: while rst_n=0, state=FETCH (0) and all outputs are forced to 0, including MemRead, instr_done and illegal_op. Fetch starts on the first rising edge after rst_n rises.
- Reset asserted mid-instruction aborts immediately, asynchronously; no partial writeback completes after the reset edge.
- Latency with zero wait states, counted FETCH through the final state:
  - R-type 4 cycles, LW 5, SW 4, ADDI 4, BEQ 3, J 3
  - illegal opcode 2 cycles
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- Write enables (RegWrite, MemWrite, PCWrite, PCWriteCond, IRWrite) are asserted only in the cycles listed above. They are never asserted in two consecutive cycles within one instruction, except that MemWrite/MemRead are held through wait states.
- instr_done and illegal_op are never asserted in the same cycle.

## Test plan
- Reset: rst_n=0 with mem_ready=1 for 3 cycles -> state=0 and all outputs 0. Release rst_n -> next cycle MemRead=1, IRWrite=1, PCWrite=1.
- R-type, mem_ready held at 1, Opcode=000000 -> state sequence 0,1,6,7,0. AluOp=10 in state 6. RegWrite=1 with RegDst=1 in state 7. instr_done high exactly one cycle.
- LW, Opcode=100011, mem_ready=0 for 2 cycles in FETCH and 3 cycles in MEMRD -> sequence 0,0,0,1,2,3,3,3,3,4,0. IRWrite is high only in the third FETCH cycle; MemtoReg=1 in state 4.
- SW then BEQ, mem_ready=1 -> SW gives 0,1,2,5,0 with MemWrite=1 and instr_done=1 in state 5. BEQ gives 0,1,8,0 with PCWriteCond=1, AluOp=01, PCSource=01.
- ADDI (001000), J (000010) and illegal (111111) back-to-back -> ADDI gives 0,1,9,10; J gives 0,1,11 with PCWrite=1, PCSource=10. Illegal gives 0,1,0 with illegal_op=1 in state 1 and no write enables asserted.
- Reset mid-operation: assert rst_n=0 during MEMRD with mem_ready=0 -> state is 0 and outputs 0 immediately, before the next clock edge. After release, a clean FETCH follows and MEMWB never occurs.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: Moore sequencer stepping the MIPS-subset datapath through fetch/decode/execute/memory/writeback
// Ports: clk, rst_n (async active-low); Opcode = IR[31:26]; mem_ready = memory completes this cycle.
//   Datapath enables/selects: PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
//   RegWrite, AluSrcA, AluSrcB, PCSource, AluOp. instr_done/illegal_op are one-cycle pulses; state is debug.
module multicycle_control_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       AluSrcA,
  output logic [1:0] AluSrcB,
  output logic [1:0] PCSource,
  output logic [1:0] AluOp,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5,
    EXECUTE = 4'd6, ALUWB = 4'd7, BRANCH = 4'd8, ADDIEX = 4'd9, ADDIWB = 4'd10, JUMP = 4'd11
  } stateT;
  stateT cur, nxt;
  assign state = cur;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cur <= FETCH;
    else cur <= nxt;
  always_comb begin
    nxt = FETCH;
    {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, AluSrcA,
     AluSrcB, PCSource, AluOp, instr_done, illegal_op} = '0;
    case (cur)
      FETCH: begin
        MemRead = 1'b1;
        AluSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        nxt = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        AluSrcB = 2'b11;
        case (Opcode)
          6'b100011, 6'b101011: nxt = MEMADR;
          6'b000000: nxt = EXECUTE;
          6'b000100: nxt = BRANCH;
          6'b001000: nxt = ADDIEX;
          6'b000010: nxt = JUMP;
          default: illegal_op = 1'b1;
        endcase
      end
      MEMADR: begin
        AluSrcA = 1'b1;
        AluSrcB = 2'b10;
        nxt = (Opcode == 6'b100011) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        IorD = 1'b1;
        MemRead = 1'b1;
        nxt = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        instr_done = 1'b1;
      end
      // A store finishes in the cycle memory accepts it, so done rides on mem_ready.
      MEMWR: begin
        IorD = 1'b1;
        MemWrite = 1'b1;
        instr_done = mem_ready;
        nxt = mem_ready ? FETCH : MEMWR;
      end
      EXECUTE: begin
        AluSrcA = 1'b1;
        AluOp = 2'b10;
        nxt = ALUWB;
      end
      ALUWB: begin
        RegDst = 1'b1;
        RegWrite = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        AluSrcA = 1'b1;
        AluOp = 2'b01;
        PCSource = 2'b01;
        PCWriteCond = 1'b1;
        instr_done = 1'b1;
      end
      ADDIEX: begin
        AluSrcA = 1'b1;
        AluSrcB = 2'b10;
        nxt = ADDIWB;
      end
      ADDIWB: begin
        RegWrite = 1'b1;
        instr_done = 1'b1;
      end
      JUMP: begin
        PCSource = 2'b10;
        PCWrite = 1'b1;
        instr_done = 1'b1;
      end
      default: nxt = FETCH;
    endcase
    // Outputs are decoded from state, so FETCH would otherwise show MemRead during reset.
    if (!rst_n)
      {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, AluSrcA,
       AluSrcB, PCSource, AluOp, instr_done, illegal_op} = '0;
  end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: randomized self-checking bench against a per-instruction cycle-trace model
module tb_multicycle_control_fsm;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] Opcode = 6'd0;
  logic mem_ready = 1'b1;
  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, AluSrcA;
  logic [1:0] AluSrcB, PCSource, AluOp;
  logic instr_done, illegal_op;
  logic [3:0] state;
  int checks = 0;
  int passed = 0;

  multicycle_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .PCSource(PCSource),
    .AluOp(AluOp), .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  logic [17:0] obs;
  assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
                AluSrcA, AluSrcB, PCSource, AluOp, instr_done, illegal_op};

  localparam logic [17:0] PW = 18'h1 << 17, PWC = 18'h1 << 16, IORD = 18'h1 << 15, MR = 18'h1 << 14;
  localparam logic [17:0] MW = 18'h1 << 13, IRW = 18'h1 << 12, M2R = 18'h1 << 11, RD = 18'h1 << 10;
  localparam logic [17:0] RW = 18'h1 << 9, ASA = 18'h1 << 8, DONE = 18'h1 << 1, ILL = 18'h1;
  function automatic logic [17:0] asb(input int v); return 18'(v) << 6; endfunction
  function automatic logic [17:0] pcs(input int v); return 18'(v) << 4; endfunction
  function automatic logic [17:0] aop(input int v); return 18'(v) << 2; endfunction

  typedef struct { logic [3:0] st; logic [5:0] op; logic rdy; logic [17:0] o; } cycT;
  cycT expq[$];

  function automatic void add(input int st, input logic rdy, input logic [17:0] o, input logic [5:0] op);
    cycT c;
    c.st = 4'(st); c.rdy = rdy; c.o = o; c.op = op;
    expq.push_back(c);
  endfunction

  function automatic logic rnd1(); return 1'($urandom); endfunction

  // Expected per-cycle trace of one instruction: fw fetch wait cycles, mw memory wait cycles.
  // Opcode is garbage during FETCH (IR not loaded yet); mem_ready is random where it must be ignored.
  function automatic void model(input logic [5:0] op, input int fw, input int mw);
    for (int i = 0; i < fw; i++) add(0, 1'b0, MR | asb(1), 6'($urandom));
    add(0, 1'b1, MR | IRW | PW | asb(1), 6'($urandom));
    case (op)
      6'd35, 6'd43: begin
        add(1, rnd1(), asb(3), op);
        add(2, rnd1(), ASA | asb(2), op);
        if (op == 6'd35) begin
          for (int i = 0; i < mw; i++) add(3, 1'b0, IORD | MR, op);
          add(3, 1'b1, IORD | MR, op);
          add(4, rnd1(), M2R | RW | DONE, op);
        end else begin
          for (int i = 0; i < mw; i++) add(5, 1'b0, IORD | MW, op);
          add(5, 1'b1, IORD | MW | DONE, op);
        end
      end
      6'd0: begin
        add(1, rnd1(), asb(3), op);
        add(6, rnd1(), ASA | aop(2), op);
        add(7, rnd1(), RD | RW | DONE, op);
      end
      6'd4: begin
        add(1, rnd1(), asb(3), op);
        add(8, rnd1(), ASA | aop(1) | pcs(1) | PWC | DONE, op);
      end
      6'd8: begin
        add(1, rnd1(), asb(3), op);
        add(9, rnd1(), ASA | asb(2), op);
        add(10, rnd1(), RW | DONE, op);
      end
      6'd2: begin
        add(1, rnd1(), asb(3), op);
        add(11, rnd1(), pcs(2) | PW | DONE, op);
      end
      default: add(1, rnd1(), asb(3) | ILL, op);
    endcase
  endfunction

  // Entered and left at posedge+1; drives each expected cycle and checks at the falling edge.
  task automatic run_queue(input string tag);
    foreach (expq[i]) begin
      mem_ready = expq[i].rdy;
      Opcode = expq[i].op;
      @(negedge clk);
      checks++;
      if (state !== expq[i].st) $display("FAIL %s cyc%0d state got %0d want %0d", tag, i, state, expq[i].st);
      else passed++;
      checks++;
      if (obs !== expq[i].o) $display("FAIL %s cyc%0d outputs got %h want %h (st %0d)", tag, i, obs, expq[i].o, expq[i].st);
      else passed++;
      @(posedge clk);
      #1;
    end
    expq.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (state !== 4'd0 || obs !== 18'd0) $display("FAIL reset_hold state %0d outputs %h want 0 0", state, obs);
      else passed++;
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== (MR | IRW | PW | asb(1))) $display("FAIL reset_release outputs %h want %h", obs, MR | IRW | PW | asb(1));
    else passed++;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_rtype();
    model(6'd0, 0, 0);
    run_queue("rtype");
  endtask

  task automatic test_lw_waits();
    model(6'd35, 2, 3);
    run_queue("lw_waits");
  endtask

  task automatic test_sw_beq();
    model(6'd43, 0, 0);
    model(6'd4, 0, 0);
    run_queue("sw_beq");
  endtask

  task automatic test_back_to_back();
    model(6'd8, 0, 0);
    model(6'd2, 0, 0);
    model(6'd63, 0, 0);
    run_queue("addi_j_ill");
  endtask

  task automatic test_random();
    logic [5:0] ops[7] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd8, 6'd2, 6'd0};
    for (int n = 0; n < 40; n++) begin
      logic [5:0] op;
      op = ops[$urandom_range(0, 5)];
      if ($urandom_range(0, 6) == 0) begin
        op = 6'($urandom);
        if (op inside {6'd0, 6'd35, 6'd43, 6'd4, 6'd8, 6'd2}) op = 6'd17;
      end
      model(op, $urandom_range(0, 3), $urandom_range(0, 3));
    end
    run_queue("random");
  endtask

  task automatic test_reset_mid();
    model(6'd35, 0, 3);
    expq = expq[0:3];
    run_queue("mid_prefix");
    mem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || obs !== 18'd0) $display("FAIL reset_mid_async state %0d outputs %h want 0 0", state, obs);
    else passed++;
    mem_ready = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    model(6'd0, 0, 0);
    run_queue("after_reset");
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_waits();
    test_sw_beq();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
